mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller that shares one 8-bit memory bus between instruction
// fetch and load/store. Reads are pipelined one byte deep; stores write one byte per cycle.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              ls_req,
  input  logic              ls_wr,
  input  logic [1:0]        ls_len,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IF_RD = 2'd1,
    LS_RD = 2'd2,
    LS_WR = 2'd3
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W-1:0] mem_a_r;
  logic [7:0]        mem_dout_r;
  logic              mem_wr_r;
  logic [2:0]        iss_r;
  logic [2:0]        cap_r;
  logic [2:0]        last_r;
  logic              issued_r;
  logic              pend_r;
  logic [31:0]       wdata_r;
  logic [31:0]       if_data_r;
  logic [31:0]       ls_rdata_r;
  logic              if_done_r;
  logic              ls_done_r;

  logic [2:0]        iss_next_s;
  logic [2:0]        ls_last_s;
  logic [ADDR_W-1:0] iss_addr_s;
  logic [ADDR_W-1:0] rew_addr_s;
  logic [7:0]        wr_byte_s;

  // Next byte address/data and the last byte index of an incoming load/store.
  always_comb begin
    iss_next_s = iss_r + 3'd1;
    iss_addr_s = base_r + ADDR_W'(iss_next_s);
    rew_addr_s = base_r + ADDR_W'(cap_r);
    wr_byte_s  = wdata_r[{iss_next_s[1:0], 3'b000} +: 8];
    case (ls_len)
      2'b00:   ls_last_s = 3'd0;
      2'b01:   ls_last_s = 3'd1;
      default: ls_last_s = 3'd3;
    endcase
  end

  // Transaction FSM: issue/capture counters, bus registers and done pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      base_r     <= '0;
      mem_a_r    <= '0;
      mem_dout_r <= 8'h00;
      mem_wr_r   <= 1'b0;
      iss_r      <= 3'd0;
      cap_r      <= 3'd0;
      last_r     <= 3'd0;
      issued_r   <= 1'b0;
      pend_r     <= 1'b0;
      wdata_r    <= 32'h0;
      if_data_r  <= 32'h0;
      ls_rdata_r <= 32'h0;
      if_done_r  <= 1'b0;
      ls_done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // A pending done pulse stays registered until rdy lets it through.
          if (rdy) begin
            if_done_r <= 1'b0;
            ls_done_r <= 1'b0;
            iss_r     <= 3'd0;
            cap_r     <= 3'd0;
            pend_r    <= 1'b0;
            if (ls_req) begin
              base_r   <= ls_addr;
              mem_a_r  <= ls_addr;
              last_r   <= ls_last_s;
              wdata_r  <= ls_wdata;
              issued_r <= ~ls_wr;
              if (ls_wr) begin
                state_r    <= LS_WR;
                mem_wr_r   <= 1'b1;
                mem_dout_r <= ls_wdata[7:0];
              end else begin
                state_r    <= LS_RD;
                ls_rdata_r <= 32'h0;
                mem_wr_r   <= 1'b0;
                mem_dout_r <= 8'h00;
              end
            end else if (if_req && !if_flush) begin
              state_r    <= IF_RD;
              base_r     <= if_addr;
              mem_a_r    <= if_addr;
              last_r     <= 3'd3;
              issued_r   <= 1'b1;
              if_data_r  <= 32'h0;
              mem_wr_r   <= 1'b0;
              mem_dout_r <= 8'h00;
            end else begin
              mem_a_r    <= '0;
              mem_wr_r   <= 1'b0;
              mem_dout_r <= 8'h00;
              issued_r   <= 1'b0;
            end
          end
        end
        IF_RD, LS_RD: begin
          if (state_r == IF_RD && if_flush) begin
            state_r  <= IDLE;
            mem_a_r  <= '0;
            issued_r <= 1'b0;
            pend_r   <= 1'b0;
            iss_r    <= 3'd0;
            cap_r    <= 3'd0;
          end else if (!rdy) begin
            // The in-flight byte is dropped; re-issue from the first uncaptured one.
            iss_r    <= cap_r;
            mem_a_r  <= rew_addr_s;
            issued_r <= 1'b1;
            pend_r   <= 1'b0;
          end else begin
            pend_r <= issued_r;
            if (issued_r && iss_r != last_r) begin
              iss_r    <= iss_next_s;
              mem_a_r  <= iss_addr_s;
              issued_r <= 1'b1;
            end else begin
              mem_a_r  <= '0;
              issued_r <= 1'b0;
            end
            if (pend_r) begin
              if (state_r == IF_RD) begin
                if_data_r[{cap_r[1:0], 3'b000} +: 8] <= mem_din;
              end else begin
                ls_rdata_r[{cap_r[1:0], 3'b000} +: 8] <= mem_din;
              end
              if (cap_r == last_r) begin
                state_r   <= IDLE;
                if_done_r <= (state_r == IF_RD);
                ls_done_r <= (state_r == LS_RD);
                mem_a_r   <= '0;
                issued_r  <= 1'b0;
                pend_r    <= 1'b0;
                iss_r     <= 3'd0;
                cap_r     <= 3'd0;
              end else begin
                cap_r <= cap_r + 3'd1;
              end
            end
          end
        end
        LS_WR: begin
          if (rdy) begin
            if (iss_r == last_r) begin
              state_r    <= IDLE;
              ls_done_r  <= 1'b1;
              mem_wr_r   <= 1'b0;
              mem_a_r    <= '0;
              mem_dout_r <= 8'h00;
              iss_r      <= 3'd0;
            end else begin
              iss_r      <= iss_next_s;
              mem_a_r    <= iss_addr_s;
              mem_dout_r <= wr_byte_s;
              mem_wr_r   <= 1'b1;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign mem_a    = mem_a_r;
  assign mem_dout = mem_dout_r;
  assign mem_wr   = mem_wr_r & rdy;
  assign if_done  = if_done_r & rdy;
  assign ls_done  = ls_done_r & rdy;
  assign if_data  = if_data_r;
  assign ls_rdata = ls_rdata_r;
  assign busy     = (state_r != IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Scenario bench for mem_ctrl: a byte memory model answers reads one cycle late, and
// expected writes and read completions are queued when stimulus is driven.
module tb_mem_ctrl;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst, rdy, if_req, if_flush, if_done;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_data;
  logic              ls_req, ls_wr, ls_done;
  logic [1:0]        ls_len;
  logic [ADDR_W-1:0] ls_addr;
  logic [31:0]       ls_wdata, ls_rdata;
  logic [7:0]        mem_din, mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr, busy;

  typedef struct { logic [31:0] data; int cyc; } rd_t;
  typedef struct { logic [31:0] addr; logic [7:0] data; int cyc; } wr_t;
  rd_t rd_q[$];
  wr_t wr_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc;

  mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_len(ls_len), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input logic [31:0] a);
    case (a)
      32'h0000_0100: pat = 8'h13;
      32'h0000_0101: pat = 8'h05;
      32'h0000_0102: pat = 8'h00;
      32'h0000_0103: pat = 8'h00;
      32'h0001_FFFE: pat = 8'h34;
      32'h0001_FFFF: pat = 8'h12;
      default:       pat = a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a, input int n);
    logic [31:0] w;
    w = 32'h0;
    for (int k = 0; k < n; k++) w[8*k +: 8] = pat(a + 32'(k));
    return w;
  endfunction

  // Read port of the memory: byte addressed in cycle c appears in cycle c+1.
  always @(posedge clk) mem_din <= pat(mem_a);

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b0; rdy = 1'b1; if_req = 1'b0; if_flush = 1'b0; if_addr = 32'h0;
    ls_req = 1'b0; ls_wr = 1'b0; ls_len = 2'b00; ls_addr = 32'h0; ls_wdata = 32'h0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({if_done, ls_done, busy, mem_wr} !== 4'b0000) begin
      n_err++; $display("FAIL reset_ctl: got %b want 0000", {if_done, ls_done, busy, mem_wr});
    end
    n_cmp++;
    if (mem_a !== 32'h0 || mem_dout !== 8'h00) begin
      n_err++; $display("FAIL reset_bus: got a=%h d=%h want 0/0", mem_a, mem_dout);
    end
    n_cmp++;
    if (if_data !== 32'h0 || ls_rdata !== 32'h0) begin
      n_err++; $display("FAIL reset_data: got %h/%h want 0/0", if_data, ls_rdata);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_fetch();
    rd_t e;
    cyc = 0; if_req = 1'b1; if_addr = 32'h100;
    rd_q.push_back('{data: 32'h0000_0513, cyc: 6});
    for (int i = 0; i < 12; i++) begin
      step();
      if (cyc >= 1 && cyc <= 4) begin
        n_cmp++;
        if (mem_a !== 32'h100 + 32'(cyc - 1) || mem_wr !== 1'b0) begin
          n_err++; $display("FAIL fetch_addr: cyc %0d got a=%h wr=%b want a=%h wr=0", cyc, mem_a, mem_wr, 32'h100 + 32'(cyc - 1));
        end
      end
      if (if_done) begin
        if_req = 1'b0; n_cmp++;
        if (rd_q.size() == 0) begin n_err++; $display("FAIL fetch_extra: if_done at cyc %0d want none", cyc); end
        else begin
          e = rd_q.pop_front();
          if (if_data !== e.data || cyc != e.cyc) begin
            n_err++; $display("FAIL fetch_done: got %h @%0d want %h @%0d", if_data, cyc, e.data, e.cyc);
          end
        end
      end
    end
    n_cmp++;
    if (rd_q.size() != 0) begin n_err++; $display("FAIL fetch_timeout: %0d pending want 0", rd_q.size()); rd_q.delete(); end
  endtask

  task automatic test_contention();
    rd_t e; wr_t w; int got_ls;
    cyc = 0; got_ls = -1;
    ls_req = 1'b1; ls_wr = 1'b1; ls_len = 2'b00; ls_addr = 32'h3_0000; ls_wdata = 32'h41;
    if_req = 1'b1; if_addr = 32'h200;
    wr_q.push_back('{addr: 32'h3_0000, data: 8'h41, cyc: 1});
    for (int i = 0; i < 14; i++) begin
      step();
      if (mem_wr) begin
        n_cmp++;
        if (wr_q.size() == 0) begin n_err++; $display("FAIL cont_extra_wr: a=%h @%0d want none", mem_a, cyc); end
        else begin
          w = wr_q.pop_front();
          if (mem_a !== w.addr || mem_dout !== w.data || cyc != w.cyc) begin
            n_err++; $display("FAIL cont_wr: got %h=%h @%0d want %h=%h @%0d", mem_a, mem_dout, cyc, w.addr, w.data, w.cyc);
          end
        end
      end
      if (cyc == 2) begin
        n_cmp++;
        if ({busy, mem_wr, mem_dout} !== 10'h0 || mem_a !== 32'h0) begin
          n_err++; $display("FAIL cont_done_bus: got busy=%b a=%h d=%h want 0", busy, mem_a, mem_dout);
        end
      end
      if (ls_done) begin
        ls_req = 1'b0; got_ls = cyc;
        rd_q.push_back('{data: word_at(32'h200, 4), cyc: cyc + 6});
      end
      if (cyc == 3) begin
        n_cmp++;
        if (mem_a !== 32'h200) begin n_err++; $display("FAIL cont_fetch_start: got %h want 200", mem_a); end
      end
      if (if_done) begin
        if_req = 1'b0; n_cmp++;
        if (rd_q.size() == 0) begin n_err++; $display("FAIL cont_extra_if: @%0d", cyc); end
        else begin
          e = rd_q.pop_front();
          if (if_data !== e.data || cyc != e.cyc) begin
            n_err++; $display("FAIL cont_fetch: got %h @%0d want %h @%0d", if_data, cyc, e.data, e.cyc);
          end
        end
      end
    end
    n_cmp++;
    if (got_ls != 2) begin n_err++; $display("FAIL cont_ls_done: got cyc %0d want 2", got_ls); end
    n_cmp++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      n_err++; $display("FAIL cont_timeout: %0d/%0d pending want 0", rd_q.size(), wr_q.size()); rd_q.delete(); wr_q.delete();
    end
  endtask

  task automatic test_half_load();
    rd_t e;
    cyc = 0; ls_req = 1'b1; ls_wr = 1'b0; ls_len = 2'b01; ls_addr = 32'h1_FFFE;
    if_req = 1'b1; if_flush = 1'b1;
    rd_q.push_back('{data: 32'h0000_1234, cyc: 4});
    for (int i = 0; i < 10; i++) begin
      step();
      if (cyc == 2) begin
        n_cmp++;
        if (mem_a !== 32'h1_FFFF) begin n_err++; $display("FAIL half_addr: got %h want 1ffff", mem_a); end
      end
      if (cyc == 6) begin
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL flush_blocks_if: busy got %b want 0", busy); end
      end
      if (if_done) begin n_cmp++; n_err++; $display("FAIL half_extra_if: @%0d want none", cyc); end
      if (ls_done) begin
        ls_req = 1'b0; n_cmp++;
        if (rd_q.size() == 0) begin n_err++; $display("FAIL half_extra: @%0d", cyc); end
        else begin
          e = rd_q.pop_front();
          if (ls_rdata !== e.data || cyc != e.cyc) begin
            n_err++; $display("FAIL half_load: got %h @%0d want %h @%0d", ls_rdata, cyc, e.data, e.cyc);
          end
        end
      end
    end
    if_req = 1'b0; if_flush = 1'b0;
    n_cmp++;
    if (rd_q.size() != 0) begin n_err++; $display("FAIL half_timeout: %0d pending want 0", rd_q.size()); rd_q.delete(); end
  endtask

  task automatic test_back_to_back();
    rd_t e; int n_done;
    cyc = 0; n_done = 0; ls_req = 1'b1; ls_wr = 1'b0; ls_len = 2'b00; ls_addr = 32'h41;
    rd_q.push_back('{data: word_at(32'h41, 1), cyc: 3});
    rd_q.push_back('{data: word_at(32'hFFFF_FFFE, 4), cyc: 9});
    for (int i = 0; i < 14; i++) begin
      step();
      if (ls_done) begin
        n_cmp++; n_done++;
        if (rd_q.size() == 0) begin n_err++; $display("FAIL b2b_extra: @%0d", cyc); end
        else begin
          e = rd_q.pop_front();
          if (ls_rdata !== e.data || cyc != e.cyc) begin
            n_err++; $display("FAIL b2b_load: got %h @%0d want %h @%0d", ls_rdata, cyc, e.data, e.cyc);
          end
        end
        if (n_done == 1) begin ls_len = 2'b10; ls_addr = 32'hFFFF_FFFE; end
        else ls_req = 1'b0;
      end
    end
    ls_req = 1'b0;
    n_cmp++;
    if (rd_q.size() != 0) begin n_err++; $display("FAIL b2b_timeout: %0d pending want 0", rd_q.size()); rd_q.delete(); end
  endtask

  task automatic test_flush();
    rd_t e;
    cyc = 0; if_req = 1'b1; if_addr = 32'h300;
    for (int i = 0; i < 14; i++) begin
      step();
      if (cyc == 3) if_flush = 1'b1;
      if (cyc == 4) begin
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %b want 0", busy); end
        if_flush = 1'b0; if_addr = 32'h310;
        rd_q.push_back('{data: word_at(32'h310, 4), cyc: 10});
      end
      if (if_done) begin
        if_req = 1'b0; n_cmp++;
        if (rd_q.size() == 0) begin n_err++; $display("FAIL flush_extra_done: @%0d want none", cyc); end
        else begin
          e = rd_q.pop_front();
          if (if_data !== e.data || cyc != e.cyc) begin
            n_err++; $display("FAIL flush_refetch: got %h @%0d want %h @%0d", if_data, cyc, e.data, e.cyc);
          end
        end
      end
    end
    n_cmp++;
    if (rd_q.size() != 0) begin n_err++; $display("FAIL flush_timeout: %0d pending want 0", rd_q.size()); rd_q.delete(); end
  endtask

  task automatic test_pause_load();
    rd_t e; logic seen;
    cyc = 0; seen = 1'b0; ls_req = 1'b1; ls_wr = 1'b0; ls_len = 2'b11; ls_addr = 32'h600;
    rd_q.push_back('{data: word_at(32'h600, 4), cyc: 8});
    for (int i = 0; i < 14; i++) begin
      step();
      if (cyc == 3) rdy = 1'b0;
      if (cyc == 4) rdy = 1'b1;
      #1;
      if (cyc == 3) begin
        n_cmp++;
        if (mem_wr !== 1'b0) begin n_err++; $display("FAIL pause_wr: got %b want 0", mem_wr); end
      end
      if (cyc >= 4 && mem_a === 32'h601) seen = 1'b1;
      if (ls_done) begin
        ls_req = 1'b0; n_cmp++;
        if (rd_q.size() == 0) begin n_err++; $display("FAIL pause_extra: @%0d", cyc); end
        else begin
          e = rd_q.pop_front();
          if (ls_rdata !== e.data || cyc != e.cyc) begin
            n_err++; $display("FAIL pause_load: got %h @%0d want %h @%0d", ls_rdata, cyc, e.data, e.cyc);
          end
        end
      end
    end
    n_cmp++;
    if (seen !== 1'b1) begin n_err++; $display("FAIL pause_reissue: got %b want 1", seen); end
    n_cmp++;
    if (rd_q.size() != 0) begin n_err++; $display("FAIL pause_timeout: %0d pending want 0", rd_q.size()); rd_q.delete(); end
  endtask

  task automatic test_pause_store();
    wr_t w; int got_ls;
    cyc = 0; got_ls = -1;
    ls_req = 1'b1; ls_wr = 1'b1; ls_len = 2'b11; ls_addr = 32'h700; ls_wdata = 32'hA1B2_C3D4;
    wr_q.push_back('{addr: 32'h700, data: 8'hD4, cyc: 1});
    wr_q.push_back('{addr: 32'h701, data: 8'hC3, cyc: 3});
    wr_q.push_back('{addr: 32'h702, data: 8'hB2, cyc: 4});
    wr_q.push_back('{addr: 32'h703, data: 8'hA1, cyc: 5});
    for (int i = 0; i < 12; i++) begin
      step();
      if (cyc == 2) rdy = 1'b0;
      if (cyc == 3) rdy = 1'b1;
      #1;
      if (mem_wr) begin
        n_cmp++;
        if (wr_q.size() == 0) begin n_err++; $display("FAIL pst_extra_wr: a=%h @%0d want none", mem_a, cyc); end
        else begin
          w = wr_q.pop_front();
          if (mem_a !== w.addr || mem_dout !== w.data || cyc != w.cyc) begin
            n_err++; $display("FAIL pst_wr: got %h=%h @%0d want %h=%h @%0d", mem_a, mem_dout, cyc, w.addr, w.data, w.cyc);
          end
        end
      end
      if (ls_done) begin ls_req = 1'b0; got_ls = cyc; end
    end
    n_cmp++;
    if (got_ls != 6) begin n_err++; $display("FAIL pst_done: got cyc %0d want 6", got_ls); end
    n_cmp++;
    if (wr_q.size() != 0) begin n_err++; $display("FAIL pst_timeout: %0d pending want 0", wr_q.size()); wr_q.delete(); end
  endtask

  task automatic test_reset_store();
    wr_t w;
    cyc = 0; ls_req = 1'b1; ls_wr = 1'b1; ls_len = 2'b11; ls_addr = 32'h800; ls_wdata = 32'h1122_3344;
    wr_q.push_back('{addr: 32'h800, data: 8'h44, cyc: 1});
    wr_q.push_back('{addr: 32'h801, data: 8'h33, cyc: 2});
    for (int i = 0; i < 10; i++) begin
      step();
      if (mem_wr) begin
        n_cmp++;
        if (wr_q.size() == 0) begin n_err++; $display("FAIL rst_extra_wr: a=%h @%0d want none", mem_a, cyc); end
        else begin
          w = wr_q.pop_front();
          if (mem_a !== w.addr || mem_dout !== w.data || cyc != w.cyc) begin
            n_err++; $display("FAIL rst_wr: got %h=%h @%0d want %h=%h @%0d", mem_a, mem_dout, cyc, w.addr, w.data, w.cyc);
          end
        end
      end
      if (ls_done) begin n_cmp++; n_err++; $display("FAIL rst_extra_done: @%0d want none", cyc); end
      if (cyc == 2) begin
        rst = 1'b0; ls_req = 1'b0;
        #1;
        n_cmp++;
        if ({busy, mem_wr, ls_done, if_done} !== 4'b0000 || mem_a !== 32'h0 || mem_dout !== 8'h00) begin
          n_err++; $display("FAIL rst_async: got busy=%b wr=%b a=%h d=%h want 0", busy, mem_wr, mem_a, mem_dout);
        end
        n_cmp++;
        if (if_data !== 32'h0 || ls_rdata !== 32'h0) begin
          n_err++; $display("FAIL rst_async_data: got %h/%h want 0/0", if_data, ls_rdata);
        end
      end
      if (cyc == 4) rst = 1'b1;
    end
    n_cmp++;
    if (wr_q.size() != 0) begin n_err++; $display("FAIL rst_pending: %0d writes missing", wr_q.size()); wr_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_contention();
    test_half_load();
    test_back_to_back();
    test_flush();
    test_pause_load();
    test_pause_store();
    test_reset_store();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
